timer_counter: RTL
==================

Name: timer_counter

Overview:
- Memory-mapped, programmable down-counter timer on the bridge; the primary hardware-interrupt source for the CP0 unit.
- Its IRQ output drives HWInt[0] into CP0, where the CPU takes the interrupt.
- The CPU programs it with sw/lw through the bridge: the bridge decodes the base address and passes the word offset, write enable and data.

Parameters:
- PRESET_INIT, 0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  2  word offset within the timer window: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- WE  input  1  write enable from the bridge. Qualified by the bridge's chip select.
- Din  input  32  write data.
- Dout  output  32  combinational read data for Addr.
- IRQ  output  1  interrupt request to CP0 HWInt[0].

Behaviour:
- Reset is asynchronous and active-high. The block clocks on posedge clk.
- Reset values:
  - CTRL=0.
  - PRESET=PRESET_INIT.
  - COUNT=0.
  - state=IDLE.
  - irq_flag=0.
  - IRQ=0.
- CTRL fields:
  - [0] Enable.
  - [2:1] Mode: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - [3] IM, the interrupt mask.
  - [31:4] read as 0 and are not stored.
- Reads (combinational):
  - Addr 0 returns {28'b0, CTRL[3:0]}.
  - Addr 1 returns PRESET.
  - Addr 2 returns COUNT.
  - Addr 3 returns 0.
- Writes take effect at the clock edge when WE=1:
  - Addr 0 writes CTRL[3:0] from Din[3:0] and clears irq_flag.
  - Addr 1 writes PRESET.
  - Addr 2 and Addr 3 are ignored; COUNT is read-only.
- IRQ = irq_flag & CTRL[3]. It is combinational from registers; there is no extra latency.
- State machine, one transition per clock:
  - IDLE: if Enable=1, go to LOAD. Otherwise stay.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT:
    - If Enable=0, go to IDLE and hold COUNT.
    - Else if COUNT<=1: COUNT <= 0, irq_flag <= 1, go to INT.
    - Else COUNT <= COUNT-1.
  - INT, Mode one-shot:
    - CTRL[0] <= 0 and irq_flag holds.
    - Go to IDLE.
    - irq_flag stays 1 until software writes CTRL or reset.
  - INT, Mode auto-reload:
    - irq_flag <= 0, so IRQ is exactly a 1-cycle pulse.
    - Go to IDLE. Enable is still 1, so the reload follows immediately.
- Period:
  - With PRESET=N≥1, IRQ rises N+2 cycles after the Enable write edge: IDLE→LOAD (1 cycle), LOAD (1 cycle), N cycles in CNT.
  - PRESET=0 behaves as PRESET=1; the interrupt fires without underflow.
  - In auto-reload, the interrupt-to-interrupt period is N+3 cycles.
- Simultaneous events:
  - A CTRL write in the same cycle as INT's one-shot Enable-clear: the software write wins, so CTRL takes Din[3:0]. irq_flag is cleared by the write, but the state still moves to IDLE.
  - A CTRL write in the same cycle as the CNT→INT irq_flag set: the set wins, so irq_flag=1.
  - A PRESET write during CNT does not affect the running COUNT. It applies at the next LOAD.
  - A CTRL write with Enable=0 during CNT/LOAD: the FSM returns to IDLE within one cycle and COUNT is frozen at its current value.
- Reset mid-count forces all registers to their reset values immediately, independent of clk.
- COUNT is unsigned 32-bit. Decrement never wraps below 0.

Decomposition:
- Shared package / header `defines:
  - register offsets TC_CTRL=0, TC_PRESET=1, TC_COUNT=2.
  - state encodings IDLE=0, LOAD=1, CNT=2, INT=3.
  - CTRL bit positions.
  - mode codes.
- Single module, no sub-module. It is one FSM plus a register file of three entries.

Test Plan:
- Reset values: assert reset mid-simulation → Dout reads 0 for CTRL, PRESET_INIT for PRESET, 0 for COUNT; IRQ=0 asynchronously, before the next clk edge.
- One-shot:
  - Stimulus: write PRESET=5, then CTRL=0x9 (IM=1, Mode=00, En=1).
  - IRQ rises exactly 7 cycles after the CTRL write edge.
  - After that, CTRL reads 0x8, COUNT=0, and IRQ stays 1.
  - Writing CTRL=0x8 drops IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → IRQ is a 1-cycle pulse every 6 cycles, for at least 3 periods; COUNT sequence is 3,2,1,0.
- Mask: PRESET=2, CTRL=0x1 (IM=0) → irq_flag is set but IRQ stays 0. Writing CTRL=0x8 clears the flag, so IRQ stays 0 after unmasking.
- Stop and retarget:
  - Mid-count (COUNT=10 of 20), write CTRL=0x8 → COUNT freezes at 9 or 10 (value of the cycle), no IRQ.
  - Write PRESET=4, then CTRL=0x9 → fresh load of 4, IRQ after 6 cycles.
- Collision and edge cases:
  - PRESET=0 with En=1 → IRQ after 3 cycles.
  - A write to Addr 2 does not change COUNT.
  - A write of CTRL=0x9 in the same cycle as the one-shot INT state → CTRL reads 0x9 and the timer restarts.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counter timer: register offsets,
// FSM state encodings, CTRL bit positions and mode codes.
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Mode codes 1x fall back to one-shot, so only 01 selects auto-reload.
    function automatic logic is_auto_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter timer on the bus bridge; IRQ feeds CP0 HWInt[0].
// Register file (CTRL/PRESET/COUNT) plus a four-state IDLE/LOAD/CNT/INT FSM.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] PRESET_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e   state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_flag_reg, irq_flag_next;
    logic        irq_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= PRESET_INIT;
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_flag_reg <= irq_flag_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ctrl_next     = ctrl_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        irq_flag_next = irq_flag_reg;
        irq_set       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ctrl_reg[CTRL_EN]) state_next = LOAD;
            end
            LOAD: begin
                count_next = preset_reg;
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl_reg[CTRL_EN]) begin
                    state_next = IDLE;
                end else if (count_reg <= 32'd1) begin
                    // Treating 0 like 1 keeps PRESET=0 from underflowing.
                    count_next    = 32'd0;
                    irq_flag_next = 1'b1;
                    irq_set       = 1'b1;
                    state_next    = INT;
                end else begin
                    count_next = count_reg - 32'd1;
                end
            end
            INT: begin
                if (is_auto_reload(ctrl_reg)) irq_flag_next = 1'b0;
                else                          ctrl_next[CTRL_EN] = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Bus writes are applied last so software overrides the one-shot
        // Enable clear, while a same-cycle interrupt set still wins.
        if (WE) begin
            case (Addr)
                TC_CTRL: begin
                    ctrl_next = Din[3:0];
                    if (!irq_set) irq_flag_next = 1'b0;
                end
                TC_PRESET: preset_next = Din;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (Addr)
            TC_CTRL:   Dout = {28'd0, ctrl_reg};
            TC_PRESET: Dout = preset_reg;
            TC_COUNT:  Dout = count_reg;
            default:   Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag_reg & ctrl_reg[CTRL_IM];

endmodule
